// File: rtl/servo_pkg.sv
// Shared types and constants for the servo control-loop sequencer and PWM users.
package servo_pkg;

  typedef enum logic [2:0] {IDLE, START, WAIT, HOLD, FAULT} servo_state_e;

  localparam int SERVO_DATA_W = 11;
  localparam int SERVO_OUT_W  = 18;
  localparam int SERVO_DUTY_W = 8;

  localparam logic [SERVO_DATA_W-1:0] ADC_MID      = 11'h400;
  localparam logic [7:0]              DUTY_NEUTRAL = 8'h80;

  function automatic int mid_scale(input int w);
    return 1 << (w - 1);
  endfunction

endpackage

// File: rtl/servo_duty_map.sv
// Maps a signed PID result to an offset-binary duty: top DUTY_W bits plus mid-scale.
module servo_duty_map
  import servo_pkg::*;
#(
  parameter int OUT_W  = SERVO_OUT_W,
  parameter int DUTY_W = SERVO_DUTY_W
) (
  input  logic [OUT_W-1:0]  pid_out,
  output logic [DUTY_W-1:0] duty_map
);

  localparam logic [DUTY_W-1:0] MID = DUTY_W'(mid_scale(DUTY_W));

  logic unused_pid_lsb;

  assign duty_map       = pid_out[OUT_W-1 -: DUTY_W] + MID;
  assign unused_pid_lsb = ^pid_out[OUT_W-DUTY_W-1:0];

endmodule

// File: rtl/servo_loop_seq.sv
// Servo loop sequencer: ADC sample -> PID start/wait -> duty commit on PWM period end.
// Optional ADC watchdog in IDLE enabled by defining SERVO_ADC_WDOG_EN.
//
// state | meaning
// IDLE  | decimate ADC samples, wait for a qualifying sample
// START | one-cycle PID start pulse, timer cleared
// WAIT  | wait for pid_done, timeout -> FAULT
// HOLD  | pending duty held until the next PWM period end
// FAULT | neutral duty, leave only when loop_en drops
module servo_loop_seq
  import servo_pkg::*;
#(
  parameter int DATA_W  = SERVO_DATA_W,
  parameter int OUT_W   = SERVO_OUT_W,
  parameter int DUTY_W  = SERVO_DUTY_W,
  parameter int DECIM   = 1,
  parameter int TIMEOUT = 4095
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              loop_en,
  input  logic              adc_done,
  input  logic [DATA_W-1:0] adc_data,
  output logic              pid_en,
  output logic [OUT_W-1:0]  pid_yk,
  input  logic              pid_done,
  input  logic [OUT_W-1:0]  pid_out,
  input  logic              pwm_period_end,
  output logic [DUTY_W-1:0] duty,
  output logic              duty_valid,
  output logic              busy,
  output logic              fault,
  output logic              overrun
);

  localparam int TW = $clog2(TIMEOUT + 1);
  localparam logic [TW-1:0] T_LAST     = TW'(TIMEOUT - 1);
  localparam logic [7:0]    DECIM_LAST = 8'(DECIM - 1);
  localparam logic [DUTY_W-1:0] NEUTRAL = (DUTY_W == SERVO_DUTY_W) ?
                                          DUTY_W'(DUTY_NEUTRAL) : DUTY_W'(mid_scale(DUTY_W));
  localparam logic [DATA_W-1:0] MID_SCALE = (DATA_W == SERVO_DATA_W) ?
                                            DATA_W'(ADC_MID) : DATA_W'(mid_scale(DATA_W));

  servo_state_e      state_q, state_d;
  logic [7:0]        decim_q, decim_d;
  logic [TW-1:0]     timer_q, timer_d;
  logic [OUT_W-1:0]  yk_q, yk_d;
  logic [DUTY_W-1:0] pending_q, pending_d;
  logic [DUTY_W-1:0] duty_q, duty_d;
  logic              dv_q, dv_d;
  logic              ovr_q, ovr_d;
  logic [DUTY_W-1:0] mapped;
  logic [DATA_W-1:0] centered;

  servo_duty_map #(.OUT_W(OUT_W), .DUTY_W(DUTY_W)) u_map (
    .pid_out  (pid_out),
    .duty_map (mapped)
  );

  // Flipping the MSB is offset-binary minus mid-scale, modulo 2^DATA_W.
  assign centered = adc_data ^ MID_SCALE;

  assign busy       = (state_q == START) || (state_q == WAIT) || (state_q == HOLD);
  assign fault      = (state_q == FAULT);
  assign pid_yk     = yk_q;
  assign duty       = duty_q;
  assign duty_valid = dv_q;
  assign overrun    = ovr_q;

  always_comb begin
    state_d   = state_q;
    decim_d   = decim_q;
    timer_d   = timer_q;
    yk_d      = yk_q;
    pending_d = pending_q;
    duty_d    = duty_q;
    dv_d      = 1'b0;
    ovr_d     = ovr_q;
    pid_en    = 1'b0;

    if (!loop_en)             ovr_d = 1'b0;
    else if (adc_done && busy) ovr_d = 1'b1;

    case (state_q)
      IDLE: begin
        if (loop_en && adc_done) begin
          timer_d = '0;
          if (decim_q == DECIM_LAST) begin
            decim_d = '0;
            yk_d    = {{(OUT_W-DATA_W){centered[DATA_W-1]}}, centered};
            state_d = START;
          end else begin
            decim_d = decim_q + 8'd1;
          end
        end
`ifdef SERVO_ADC_WDOG_EN
        else if (loop_en) begin
          if (timer_q == T_LAST) state_d = FAULT;
          else                   timer_d = timer_q + 1'b1;
        end
`endif
      end
      START: begin
        pid_en  = loop_en;
        timer_d = '0;
        state_d = WAIT;
      end
      WAIT: begin
        if (pid_done) begin
          pending_d = mapped;
          state_d   = HOLD;
        end else if (timer_q == T_LAST) begin
          state_d = FAULT;
        end else begin
          timer_d = timer_q + 1'b1;
        end
      end
      HOLD: begin
        if (pwm_period_end) begin
          duty_d  = pending_q;
          dv_d    = 1'b1;
          timer_d = '0;
          state_d = IDLE;
        end
      end
      FAULT: begin
        if (!loop_en) begin
          decim_d = '0;
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase

    if (!loop_en) timer_d = '0;

    // Disabling the loop or faulting forces neutral duty; pending is simply never committed.
    if (state_q != FAULT && (!loop_en || state_d == FAULT)) begin
      if (!loop_en) state_d = IDLE;
      duty_d = NEUTRAL;
      dv_d   = (duty_q != NEUTRAL);
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q   <= IDLE;
      decim_q   <= '0;
      timer_q   <= '0;
      yk_q      <= '0;
      pending_q <= NEUTRAL;
      duty_q    <= NEUTRAL;
      dv_q      <= 1'b0;
      ovr_q     <= 1'b0;
    end else begin
      state_q   <= state_d;
      decim_q   <= decim_d;
      timer_q   <= timer_d;
      yk_q      <= yk_d;
      pending_q <= pending_d;
      duty_q    <= duty_d;
      dv_q      <= dv_d;
      ovr_q     <= ovr_d;
    end
  end

endmodule

// File: tb/tb_servo_loop_seq.sv
// Directed bench for servo_loop_seq with DECIM=4 and a short TIMEOUT.
module tb_servo_loop_seq;

  localparam int T = 40;

  logic        clk = 1'b0;
  logic        rst;
  logic        loop_en;
  logic        adc_done;
  logic [10:0] adc_data;
  logic        pid_en;
  logic [17:0] pid_yk;
  logic        pid_done;
  logic [17:0] pid_out;
  logic        pwm_period_end;
  logic [7:0]  duty;
  logic        duty_valid;
  logic        busy;
  logic        fault;
  logic        overrun;

  int checks = 0;
  int errors = 0;
  int pen_cnt = 0;
  int dv_cnt = 0;

  servo_loop_seq #(.DATA_W(11), .OUT_W(18), .DUTY_W(8), .DECIM(4), .TIMEOUT(T)) dut (
    .clk            (clk),
    .rst            (rst),
    .loop_en        (loop_en),
    .adc_done       (adc_done),
    .adc_data       (adc_data),
    .pid_en         (pid_en),
    .pid_yk         (pid_yk),
    .pid_done       (pid_done),
    .pid_out        (pid_out),
    .pwm_period_end (pwm_period_end),
    .duty           (duty),
    .duty_valid     (duty_valid),
    .busy           (busy),
    .fault          (fault),
    .overrun        (overrun)
  );

  always #5 clk = ~clk;

  always @(posedge clk) begin
    if (pid_en)     pen_cnt++;
    if (duty_valid) dv_cnt++;
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic pulse_adc(input logic [10:0] d);
    adc_data = d;
    adc_done = 1'b1;
    step(1);
    adc_done = 1'b0;
  endtask

  initial begin
    rst = 1'b0; loop_en = 1'b0; adc_done = 1'b0; adc_data = '0;
    pid_done = 1'b0; pid_out = '0; pwm_period_end = 1'b0;
    #12;
    chk("rst_duty", 32'(duty), 32'h80);
    chk("rst_yk", 32'(pid_yk), 32'h0);
    chk("rst_busy", 32'(busy), 32'h0);
    chk("rst_fault", 32'(fault), 32'h0);
    chk("rst_overrun", 32'(overrun), 32'h0);
    rst = 1'b1;
    step(1);
    chk("rel_pid_en", 32'(pid_en), 32'h0);
    chk("rel_dv", 32'(duty_valid), 32'h0);

    // mid-scale sample, full negative PID result -> duty 00
    loop_en = 1'b1;
    repeat (3) pulse_adc(11'h400);
    chk("t1_decim_pid_en", 32'(pid_en), 32'h0);
    chk("t1_decim_busy", 32'(busy), 32'h0);
    pulse_adc(11'h400);
    chk("t1_pid_en", 32'(pid_en), 32'h1);
    chk("t1_yk", 32'(pid_yk), 32'h0);
    step(1);
    chk("t1_pid_en_once", 32'(pid_en), 32'h0);
    pid_done = 1'b1; pid_out = 18'h20000; pwm_period_end = 1'b1;
    step(1);
    pid_done = 1'b0; pwm_period_end = 1'b0;
    chk("t1_hold_busy", 32'(busy), 32'h1);
    chk("t1_coincident_pwm_dv", 32'(duty_valid), 32'h0);
    step(1);
    chk("t1_hold_duty", 32'(duty), 32'h80);
    pwm_period_end = 1'b1;
    step(1);
    pwm_period_end = 1'b0;
    chk("t1_duty", 32'(duty), 32'h00);
    chk("t1_dv", 32'(duty_valid), 32'h1);
    step(1);
    chk("t1_dv_once", 32'(duty_valid), 32'h0);
    chk("t1_idle", 32'(busy), 32'h0);

    // full-scale samples, overrun during WAIT, positive PID result -> duty FF
    repeat (3) pulse_adc(11'h7FF);
    pulse_adc(11'h7FF);
    chk("t2_pid_en", 32'(pid_en), 32'h1);
    chk("t2_yk", 32'(pid_yk), 32'h3FF);
    step(1);
    pulse_adc(11'h7FF);
    chk("t2_overrun", 32'(overrun), 32'h1);
    chk("t2_no_extra_pid_en", 32'(pid_en), 32'h0);
    pid_done = 1'b1; pid_out = 18'h1FFFF;
    step(1);
    pid_done = 1'b0;
    pwm_period_end = 1'b1;
    step(1);
    pwm_period_end = 1'b0;
    chk("t2_duty", 32'(duty), 32'hFF);
    chk("t2_dv", 32'(duty_valid), 32'h1);
    repeat (3) pulse_adc(11'h7FF);
    chk("t2_decim_untouched", 32'(pid_en), 32'h0);
    pulse_adc(11'h7FF);
    chk("t2_pid_en2", 32'(pid_en), 32'h1);
    step(1);
    chk("t2_pid_en_count", 32'(pen_cnt), 32'd3);
    chk("t2_overrun_sticky", 32'(overrun), 32'h1);

    // PID never answers -> FAULT at pid_en + T + 1
    step(T - 1);
    chk("t3_no_fault_yet", 32'(fault), 32'h0);
    step(1);
    chk("t3_fault", 32'(fault), 32'h1);
    chk("t3_duty", 32'(duty), 32'h80);
    chk("t3_dv", 32'(duty_valid), 32'h1);
    chk("t3_busy", 32'(busy), 32'h0);
    pulse_adc(11'h400);
    chk("t3_no_pid_en_in_fault", 32'(pid_en), 32'h0);
    chk("t3_fault_held", 32'(fault), 32'h1);
    loop_en = 1'b0;
    step(1);
    chk("t3_exit_fault", 32'(fault), 32'h0);
    chk("t3_overrun_clr", 32'(overrun), 32'h0);
    loop_en = 1'b1;

    // loop_en dropped in HOLD with pending 10 -> never applied
    repeat (4) pulse_adc(11'h000);
    chk("t4_yk_neg", 32'(pid_yk), 32'h3FC00);
    step(1);
    pid_done = 1'b1; pid_out = 18'h24000;
    step(1);
    pid_done = 1'b0;
    chk("t4_hold", 32'(busy), 32'h1);
    loop_en = 1'b0; pwm_period_end = 1'b1;
    step(1);
    pwm_period_end = 1'b0;
    chk("t4_duty_neutral", 32'(duty), 32'h80);
    chk("t4_no_dv", 32'(duty_valid), 32'h0);
    chk("t4_idle", 32'(busy), 32'h0);
    loop_en = 1'b1; pwm_period_end = 1'b1;
    step(1);
    pwm_period_end = 1'b0;
    pid_done = 1'b1; pid_out = 18'h3FFFF;
    step(1);
    pid_done = 1'b0;
    chk("t4_late_done_ignored", 32'(busy), 32'h0);
    step(2);
    chk("t4_duty_final", 32'(duty), 32'h80);
    chk("t4_dv_count", 32'(dv_cnt), 32'd3);
    chk("t4_pid_en_total", 32'(pen_cnt), 32'd4);

    // idle watchdog
`ifdef SERVO_ADC_WDOG_EN
    step(T + 1);
    chk("t5_wdog_fault", 32'(fault), 32'h1);
`else
    step(10 * T);
    chk("t5_no_wdog_fault", 32'(fault), 32'h0);
`endif

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/servo_loop_seq.md
Name: servo_loop_seq

Overview:
- Control-loop sequencer for the servo datapath: ADC receiver → PID → PWM.
- Captures ADC samples, decimates them, and converts each to a signed error input.
- Issues one start pulse to the PID, waits for its result, and maps it to an 8-bit duty value.
- Commits the duty to the PWM only on a PWM period boundary; enforces timeouts and a safe neutral duty on fault.

Parameters:
- DATA_W, 11, ADC sample width (offset-binary; mid-scale = 2^(DATA_W-1)).
- OUT_W, 18, PID input/output width, signed.
- DUTY_W, 8, PWM duty width.
- DECIM, 1, process every DECIM-th adc_done; legal range 1..255.
- TIMEOUT, 4095, cycle limit for PID completion (and for the ADC watchdog when enabled).

Ports:
- clk  in  1  system clock; everything is rising-edge.
- rst  in  1  asynchronous, active-low reset.
- loop_en  in  1  loop enable (level).
- adc_done  in  1  single-cycle pulse, synchronous to clk; adc_data is valid in the same cycle.
- adc_data  in  DATA_W  offset-binary ADC sample.
- pid_en  out  1  single-cycle PID start pulse.
- pid_yk  out  OUT_W  signed PID input; held stable from pid_en until pid_done.
- pid_done  in  1  single-cycle PID completion pulse.
- pid_out  in  OUT_W  signed PID result; valid while pid_done is high.
- pwm_period_end  in  1  single-cycle pulse at PWM counter wrap.
- duty  out  DUTY_W  duty value delivered to the PWM.
- duty_valid  out  1  single-cycle pulse when duty changes.
- busy  out  1  high in every state except IDLE and FAULT.
- fault  out  1  high while in FAULT.
- overrun  out  1  sticky flag: adc_done arrived while busy; cleared by reset or loop_en=0.

Behaviour:
- Reset values (rst low, asynchronous): state=IDLE; duty=2^(DUTY_W-1) (8'h80); pid_yk=0; decimation count=0; timer=0; all pulse outputs and flags 0.
- IDLE: on adc_done && loop_en, increment the decimation counter.
  - When the counter reaches DECIM-1: clear it, latch pid_yk = sign-extend(adc_data − 2^(DATA_W-1)), go to START.
  - Example: adc_data 11'h400 → pid_yk 0; 11'h000 → −1024.
- START: pid_en=1 for exactly one cycle; clear the timer; go to WAIT.
- WAIT: the timer increments every cycle.
  - On pid_done: pending = pid_out[OUT_W-1 -: DUTY_W] + 2^(DUTY_W-1), i.e. the MSB inverted, wrap mod 2^DUTY_W; go to HOLD.
  - If the timer reaches TIMEOUT without pid_done: go to FAULT.
  - If pid_done and the timeout land in the same cycle, pid_done wins.
- HOLD: on pwm_period_end, duty<=pending and duty_valid=1 for one cycle; go to IDLE.
  - If pwm_period_end coincides with entry to HOLD, it is not used; wait for the next one.
- Latency: pid_en occurs 1 cycle after the qualifying adc_done. Duty commit occurs on the first pwm_period_end strictly after the cycle pid_done is seen.
- adc_done while busy: the sample is dropped and overrun is set; the decimation counter is untouched.
- loop_en=0 in IDLE/START/WAIT/HOLD: next state is IDLE, pending is discarded, duty<=8'h80 immediately with a duty_valid pulse if duty changed. A PID still in flight is ignored; a late pid_done in IDLE is ignored.
- FAULT: duty<=8'h80 on entry (duty_valid pulse if changed); fault=1; pid_en never asserted. Exit to IDLE only when loop_en=0. The decimation counter is cleared on exit.
- pid_en and duty_valid are never asserted in the same cycle as a reset release.

Optional Feature:
- Macro: SERVO_ADC_WDOG_EN.
- Defined: in IDLE with loop_en=1, the timer counts cycles since the last adc_done; reaching TIMEOUT → FAULT. The timer clears on every adc_done and whenever loop_en=0.
- Undefined: IDLE waits indefinitely; the timer is used only in WAIT.

Decomposition:
- Shared package servo_pkg holds:
  - state enum IDLE/START/WAIT/HOLD/FAULT;
  - localparam DUTY_NEUTRAL = 8'h80;
  - ADC mid-scale constant;
  - DATA_W/OUT_W/DUTY_W defaults.
- One natural sub-module: servo_duty_map, combinational MSB-slice plus offset, reused by other PWM users.
- FSM, decimator and timer stay in the top of this block.

Test Plan:
- Reset then loop_en=1; adc_done with 11'h400; PID returns pid_done with pid_out=18'h20000 → pending 8'h00; next pwm_period_end → duty=8'h00 with a duty_valid pulse.
- DECIM=4; 8 adc_done pulses with data 11'h7FF → exactly 2 pid_en pulses, pid_yk=+1023.
- PID never responds → fault=1 at pid_en+TIMEOUT+1 cycles, duty=8'h80; loop_en=0 → IDLE, fault=0.
- adc_done during WAIT → overrun=1, no extra pid_en; pid_out=18'h1FFFF → duty 8'hFF.
- loop_en dropped in HOLD with pending 8'h10 → duty stays or returns to 8'h80, pending never applied.
- With SERVO_ADC_WDOG_EN: no adc_done for TIMEOUT cycles → FAULT. Without it: no fault after 10×TIMEOUT cycles.
